axi_lite_to_reg: RTL and testbench
==================================

# axi_lite_to_reg

Terminal AXI4-Lite slave that converts AXI4-Lite transactions into single-beat accesses on a simple request/ready register bus. It sits directly downstream of an AXI-Lite cut chain, consumes its master port, and feeds peripheral register files. It serialises reads and writes, arbitrates fairly between them, and returns SLVERR on peripheral error or on a watchdog timeout.

## Interface
- AddrWidth, 32, width of the register-bus address; AXI-Lite address LSBs are forwarded unchanged.
- DataWidth, 32, data width; strobe width is DataWidth/8.
- TimeoutCycles, 32'd256, maximum cycles that reg_req_o may stay high without reg_ready_i; 0 disables the watchdog.
- req_t, logic, AXI-Lite request struct with fields aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready.
- resp_t, logic, AXI-Lite response struct with fields aw_ready, w_ready, b, b_valid, ar_ready, r, r_valid.
- clk_i  in  1  clock; the block uses this single clock only.
- rst_ni  in  1  asynchronous, active-low reset.
- slv_req_i  in  req_t  AXI-Lite request.
- slv_resp_o  out  resp_t  AXI-Lite response.
- reg_req_o  out  1  register access valid.
- reg_write_o  out  1  1 = write, 0 = read.
- reg_addr_o  out  AddrWidth  access address.
- reg_wdata_o  out  DataWidth  write data.
- reg_wstrb_o  out  DataWidth/8  write byte strobes.
- reg_ready_i  in  1  access complete; sampled only while reg_req_o is high.
- reg_rdata_i  in  DataWidth  read data, valid with reg_ready_i.
- reg_error_i  in  1  access error, valid with reg_ready_i.

## Operation
- FSM states: IDLE, ACCESS, B_RESP, R_RESP.
- IDLE, write pending (aw_valid && w_valid):
  - aw_ready and w_ready are driven high together in the same cycle.
  - addr, data and strb are latched; write=1; go to ACCESS.
- IDLE, read pending (ar_valid):
  - ar_ready is driven high; addr is latched; write=0; go to ACCESS.
- A lone aw_valid or a lone w_valid is never accepted; the block waits until both are valid.
- Both a write and a read pending in IDLE: the block grants the opposite of the last grant. A 1-bit last_grant register resets to "write", so the first contested grant goes to the read.
- ACCESS:
  - reg_req_o=1 with the latched fields held stable.
  - On reg_ready_i: capture status = reg_error_i ? SLVERR (2'b10) : OKAY (2'b00).
  - On a read, also capture rdata. Go to B_RESP (write) or R_RESP (read).
- Watchdog:
  - A counter is cleared on ACCESS entry and increments every ACCESS cycle without reg_ready_i.
  - When it reaches TimeoutCycles, the block drops reg_req_o, sets status=SLVERR, forces rdata=0 and leaves ACCESS.
  - A reg_ready_i in that same cycle takes priority over the timeout.
- B_RESP: b_valid=1, b.resp=status. Return to IDLE on b_ready.
- R_RESP: r_valid=1, r.data=rdata, r.resp=status. Return to IDLE on r_ready.
- aw.prot and ar.prot are ignored.
- Counter width is $clog2(TimeoutCycles+1), minimum 1 bit.

## Timing
- Reset values: all slv_resp_o fields 0, reg_req_o=0, reg_write_o=0, reg_addr_o/reg_wdata_o/reg_wstrb_o=0, FSM=IDLE, last_grant=write, counter=0.
- Ready signals: aw_ready, w_ready and ar_ready are combinational from state and the valids. They are high only in IDLE.
- Latency: request handshake in cycle N; reg_req_o rises in cycle N+1.
  - reg_ready_i in cycle N+1 gives b_valid/r_valid in cycle N+2.
  - Minimum round-trip is 3 cycles; throughput is one transaction per 3 cycles.
- Outputs: reg_* outputs are registered and stable for the whole ACCESS state. b_valid/r_valid stay high until the matching ready; payloads are stable while valid.
- Outstanding transactions: at most one. No new request is accepted outside IDLE.
- Reset mid-access: all outputs return to their reset values immediately (asynchronously). Any pending AXI transaction is dropped.

## Test plan
- Write at addr 0x10, data 0xDEADBEEF, strb 0xF; reg_ready_i in the first ACCESS cycle -> reg_write_o=1 with matching fields, b.resp=2'b00, b_valid in cycle N+2.
- Read at addr 0x20; reg_rdata_i=0x12345678 with reg_ready_i after 3 wait cycles -> r.data=0x12345678, r.resp=2'b00, r_valid 5 cycles after the AR handshake.
- AW and AR presented together out of reset, repeated twice -> grant order read, write, read, write; aw_ready is never high in the same cycle as ar_ready.
- Write with reg_error_i=1 -> b.resp=2'b10. aw_valid alone for 5 cycles before w_valid -> no handshake until both are high.
- TimeoutCycles=4, reg_ready_i held low on a read -> reg_req_o drops after 4 ACCESS cycles, r.resp=2'b10, r.data=0. Then r_ready held low 3 cycles -> r_valid stays high with a stable payload.
- rst_ni asserted during ACCESS -> reg_req_o=0 and slv_resp_o all-zero immediately. After release, a new read completes normally.

Source files
------------

// File: rtl/axi_lite_to_reg.sv
// AXI4-Lite slave terminating into a single-beat request/ready register bus.
// One transaction in flight; reads and writes alternate when both are pending.

package axi_lite_to_reg_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } aw_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_chan_t;

    typedef struct packed {
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } ar_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } resp_t;
endpackage

module axi_lite_to_reg #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 32'd256,
    parameter type         req_t         = axi_lite_to_reg_pkg::req_t,
    parameter type         resp_t        = axi_lite_to_reg_pkg::resp_t
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  req_t                   slv_req_i,
    output resp_t                  slv_resp_o,
    output logic                   reg_req_o,
    output logic                   reg_write_o,
    output logic [AddrWidth-1:0]   reg_addr_o,
    output logic [DataWidth-1:0]   reg_wdata_o,
    output logic [DataWidth/8-1:0] reg_wstrb_o,
    input  logic                   reg_ready_i,
    input  logic [DataWidth-1:0]   reg_rdata_i,
    input  logic                   reg_error_i
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned CntBits   = $clog2(TimeoutCycles + 1);
    localparam int unsigned CntWidth  = (CntBits < 1) ? 1 : CntBits;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_B_RESP = 2'd2;
    localparam logic [1:0] ST_R_RESP = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [1:0]           r_state;
    logic                 r_last_wr;
    logic [CntWidth-1:0]  r_cnt;
    logic                 r_req;
    logic                 r_write;
    logic [AddrWidth-1:0] r_addr;
    logic [DataWidth-1:0] r_wdata;
    logic [StrbWidth-1:0] r_wstrb;
    logic [DataWidth-1:0] r_rdata;
    logic [1:0]           r_status;

    logic w_idle;
    logic w_wr_pend;
    logic w_rd_pend;
    logic w_grant_wr;
    logic w_grant_rd;
    logic w_aw_hs;
    logic w_ar_hs;
    logic w_timeout;
    logic w_unused;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_wr_pend = slv_req_i.aw_valid && slv_req_i.w_valid;
    assign w_rd_pend = slv_req_i.ar_valid;

    // Contested requests go to whichever side did not win the previous grant.
    assign w_grant_wr = w_wr_pend && (!w_rd_pend || !r_last_wr);
    assign w_grant_rd = w_rd_pend && !w_grant_wr;
    assign w_aw_hs    = w_idle && w_grant_wr;
    assign w_ar_hs    = w_idle && w_grant_rd;

    // Fires on the last allowed ACCESS cycle; a same-cycle ready wins.
    assign w_timeout = (TimeoutCycles != 0) && !reg_ready_i && (r_cnt == CntLast);

    assign w_unused = ^{slv_req_i.aw.prot, slv_req_i.ar.prot};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_last_wr <= 1'b1;
            r_cnt     <= '0;
            r_req     <= 1'b0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_status  <= RESP_OKAY;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_aw_hs) begin
                        r_addr    <= AddrWidth'(slv_req_i.aw.addr);
                        r_wdata   <= DataWidth'(slv_req_i.w.data);
                        r_wstrb   <= StrbWidth'(slv_req_i.w.strb);
                        r_write   <= 1'b1;
                        r_req     <= 1'b1;
                        r_cnt     <= '0;
                        r_last_wr <= 1'b1;
                        r_state   <= ST_ACCESS;
                    end else if (w_ar_hs) begin
                        r_addr    <= AddrWidth'(slv_req_i.ar.addr);
                        r_wdata   <= '0;
                        r_wstrb   <= '0;
                        r_write   <= 1'b0;
                        r_req     <= 1'b1;
                        r_cnt     <= '0;
                        r_last_wr <= 1'b0;
                        r_state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (reg_ready_i) begin
                        r_req    <= 1'b0;
                        r_status <= reg_error_i ? RESP_SLVERR : RESP_OKAY;
                        if (!r_write) begin
                            r_rdata <= reg_rdata_i;
                        end
                        r_state <= r_write ? ST_B_RESP : ST_R_RESP;
                    end else if (w_timeout) begin
                        r_req    <= 1'b0;
                        r_status <= RESP_SLVERR;
                        r_rdata  <= '0;
                        r_state  <= r_write ? ST_B_RESP : ST_R_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_B_RESP: begin
                    if (slv_req_i.b_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    if (slv_req_i.r_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = w_aw_hs;
        slv_resp_o.w_ready  = w_aw_hs;
        slv_resp_o.ar_ready = w_ar_hs;
        slv_resp_o.b_valid  = (r_state == ST_B_RESP);
        slv_resp_o.b.resp   = r_status;
        slv_resp_o.r_valid  = (r_state == ST_R_RESP);
        slv_resp_o.r.data   = r_rdata;
        slv_resp_o.r.resp   = r_status;
    end

    assign reg_req_o   = r_req;
    assign reg_write_o = r_write;
    assign reg_addr_o  = r_addr;
    assign reg_wdata_o = r_wdata;
    assign reg_wstrb_o = r_wstrb;

endmodule

// File: tb/tb_axi_lite_to_reg.sv
// Self-checking bench for axi_lite_to_reg: directed table, corner sequences,
// and random traffic checked against a transaction-level reference model.

module tb_axi_lite_to_reg;
    import axi_lite_to_reg_pkg::*;

    localparam int T = 4;

    logic        clk;
    logic        rst_ni;
    req_t        req;
    resp_t       resp;
    logic        reg_req_o;
    logic        reg_write_o;
    logic [31:0] reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic [3:0]  reg_wstrb_o;
    logic        reg_ready_i;
    logic [31:0] reg_rdata_i;
    logic        reg_error_i;

    int checks   = 0;
    int failures = 0;
    int txn_no   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          lat;
        bit          err;
    } txn_t;

    typedef struct {
        bit          is_write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          lat;
        bit          err;
        int          hold;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    txn_t wt;
    txn_t rt;
    bit   model_last_write;

    axi_lite_to_reg #(
        .AddrWidth    (32),
        .DataWidth    (32),
        .TimeoutCycles(T)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .slv_req_i  (req),
        .slv_resp_o (resp),
        .reg_req_o  (reg_req_o),
        .reg_write_o(reg_write_o),
        .reg_addr_o (reg_addr_o),
        .reg_wdata_o(reg_wdata_o),
        .reg_wstrb_o(reg_wstrb_o),
        .reg_ready_i(reg_ready_i),
        .reg_rdata_i(reg_rdata_i),
        .reg_error_i(reg_error_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL sim_time_limit: got no finish required finish");
        $fatal(1, "time limit");
    end

    // Reference model: response code, read data and ACCESS length from wait count.
    function automatic logic [1:0] m_resp(input int lat, input bit err);
        if (lat >= T) return 2'b10;
        return err ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [31:0] m_rdata(input int lat, input logic [31:0] data);
        return (lat >= T) ? 32'h0 : data;
    endfunction

    function automatic int m_access_cycles(input int lat);
        return (lat < T) ? lat + 1 : T;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Entered and left on a negedge. Drives the requested channels, checks the
    // grant, plays the peripheral, then checks and retires the response.
    task automatic run_txn(input bit pw, input bit pr, input bit exp_w,
                           input logic [1:0] exp_resp, input logic [31:0] exp_rd,
                           input int hold);
        txn_t t;
        int   n;
        t = exp_w ? wt : rt;
        req.aw.addr  = wt.addr;
        req.aw.prot  = 3'($urandom);
        req.w.data   = wt.data;
        req.w.strb   = wt.strb;
        req.ar.addr  = rt.addr;
        req.ar.prot  = 3'($urandom);
        req.aw_valid = pw;
        req.w_valid  = pw;
        req.ar_valid = pr;
        #1;
        n = 0;
        while (!(resp.aw_ready || resp.ar_ready) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!(resp.aw_ready || resp.ar_ready)) begin
            chk("handshake_timeout", 1'b0, 1'b1);
            req.aw_valid = 1'b0;
            req.w_valid  = 1'b0;
            req.ar_valid = 1'b0;
            return;
        end
        chk("ready_exclusive", resp.aw_ready && resp.ar_ready, 1'b0);
        chk("w_ready_with_aw", resp.w_ready, resp.aw_ready);
        chk("grant_is_write", resp.aw_ready, exp_w);
        model_last_write = exp_w;

        @(negedge clk);
        if (exp_w) begin
            req.aw_valid = 1'b0;
            req.w_valid  = 1'b0;
        end else begin
            req.ar_valid = 1'b0;
        end
        n = m_access_cycles(t.lat);
        for (int j = 0; j < n; j++) begin
            if (j > 0) @(negedge clk);
            chk("reg_req_high", reg_req_o, 1'b1);
            chk("reg_write", reg_write_o, exp_w);
            chk("reg_addr", reg_addr_o, t.addr);
            if (exp_w) begin
                chk("reg_wdata", reg_wdata_o, t.data);
                chk("reg_wstrb", reg_wstrb_o, t.strb);
            end
            chk("no_resp_in_access", {resp.b_valid, resp.r_valid}, 2'b00);
            reg_ready_i = (j == t.lat);
            reg_error_i = t.err;
            reg_rdata_i = (j == t.lat) ? t.data : $urandom;
            #1;
            chk("no_accept_in_access", {resp.aw_ready, resp.w_ready, resp.ar_ready}, 3'b000);
        end

        @(negedge clk);
        reg_ready_i = 1'b0;
        reg_error_i = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            chk("reg_req_low", reg_req_o, 1'b0);
            if (exp_w) begin
                chk("b_valid", resp.b_valid, 1'b1);
                chk("r_valid_idle", resp.r_valid, 1'b0);
                chk("b_resp", resp.b.resp, exp_resp);
            end else begin
                chk("r_valid", resp.r_valid, 1'b1);
                chk("b_valid_idle", resp.b_valid, 1'b0);
                chk("r_resp", resp.r.resp, exp_resp);
                chk("r_data", resp.r.data, exp_rd);
            end
        end
        txn_no++;
        $display("txn %0d %s addr=0x%08h lat=%0d resp=%0d rdata=0x%08h",
                 txn_no, exp_w ? "WR" : "RD", t.addr, t.lat,
                 exp_w ? resp.b.resp : resp.r.resp, resp.r.data);
        if (exp_w) req.b_ready = 1'b1;
        else       req.r_ready = 1'b1;
        @(negedge clk);
        req.b_ready = 1'b0;
        req.r_ready = 1'b0;
        chk("valid_cleared", {resp.b_valid, resp.r_valid}, 2'b00);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0,  1'b0, 0, 2'b00, 32'h0};
        vecs[1] = '{1'b0, 32'h20, 32'h12345678, 4'h0, 3,  1'b0, 1, 2'b00, 32'h12345678};
        vecs[2] = '{1'b1, 32'h30, 32'hCAFEF00D, 4'h3, 1,  1'b1, 0, 2'b10, 32'h0};
        vecs[3] = '{1'b0, 32'h40, 32'h55AA55AA, 4'h0, 10, 1'b0, 3, 2'b10, 32'h0};
        vecs[4] = '{1'b0, 32'h44, 32'hA5A5A5A5, 4'h0, 0,  1'b1, 0, 2'b10, 32'hA5A5A5A5};
        vecs[5] = '{1'b1, 32'h48, 32'h01020304, 4'hC, 3,  1'b0, 2, 2'b00, 32'h0};
        vecs[6] = '{1'b0, 32'h4C, 32'h0BADF00D, 4'h0, 2,  1'b0, 0, 2'b00, 32'h0BADF00D};

        req         = '0;
        rst_ni      = 1'b0;
        reg_ready_i = 1'b0;
        reg_rdata_i = '0;
        reg_error_i = 1'b0;
        model_last_write = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_reg_req", reg_req_o, 1'b0);
        chk("rst_reg_write", reg_write_o, 1'b0);
        chk("rst_reg_addr", reg_addr_o, 32'h0);
        chk("rst_reg_wdata", reg_wdata_o, 32'h0);
        chk("rst_reg_wstrb", reg_wstrb_o, 4'h0);
        chk("rst_resp", resp, 64'h0);
        rst_ni = 1'b1;
        @(negedge clk);

        // Contested AW+AR straight out of reset, twice: read, write, read, write.
        for (int k = 0; k < 2; k++) begin
            wt = '{32'h100 + k, 32'hA0A0_0000 + k, 4'hF, 0, 1'b0};
            rt = '{32'h200 + k, 32'hB0B0_0000 + k, 4'h0, 1, 1'b0};
            run_txn(1'b1, 1'b1, 1'b0, 2'b00, rt.data, 0);
            run_txn(1'b1, 1'b0, 1'b1, 2'b00, 32'h0, 0);
        end

        // Lone AW must not be accepted until W joins it.
        wt = '{32'h300, 32'h11223344, 4'h5, 0, 1'b0};
        req.aw.addr  = wt.addr;
        req.aw_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("lone_aw_no_aw_ready", resp.aw_ready, 1'b0);
            chk("lone_aw_no_w_ready", resp.w_ready, 1'b0);
            @(negedge clk);
        end
        run_txn(1'b1, 1'b0, 1'b1, 2'b00, 32'h0, 0);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].is_write) begin
                wt = '{vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].lat, vecs[i].err};
                run_txn(1'b1, 1'b0, 1'b1, vecs[i].exp_resp, vecs[i].exp_rdata, vecs[i].hold);
            end else begin
                rt = '{vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].lat, vecs[i].err};
                run_txn(1'b0, 1'b1, 1'b0, vecs[i].exp_resp, vecs[i].exp_rdata, vecs[i].hold);
            end
        end

        // Reset in the middle of an access, then a clean read.
        rt = '{32'h500, 32'h0, 4'h0, 0, 1'b0};
        req.ar.addr  = rt.addr;
        req.ar_valid = 1'b1;
        #1;
        chk("rst_mid_ar_ready", resp.ar_ready, 1'b1);
        @(negedge clk);
        req.ar_valid = 1'b0;
        chk("rst_mid_in_access", reg_req_o, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_reg_req", reg_req_o, 1'b0);
        chk("rst_mid_resp", resp, 64'h0);
        chk("rst_mid_reg_addr", reg_addr_o, 32'h0);
        chk("rst_mid_reg_write", reg_write_o, 1'b0);
        @(negedge clk);
        rst_ni = 1'b1;
        model_last_write = 1'b1;
        @(negedge clk);
        rt = '{32'h504, 32'h76543210, 4'h0, 1, 1'b0};
        run_txn(1'b0, 1'b1, 1'b0, 2'b00, 32'h76543210, 0);

        for (int i = 0; i < 40; i++) begin
            int mode;
            int hold;
            mode = $urandom_range(0, 2);
            hold = $urandom_range(0, 3);
            wt = '{{20'h0, 12'($urandom)}, $urandom, 4'($urandom), $urandom_range(0, 6),
                   ($urandom_range(0, 3) == 0)};
            rt = '{{20'h0, 12'($urandom)}, $urandom, 4'h0, $urandom_range(0, 6),
                   ($urandom_range(0, 3) == 0)};
            if (mode == 0) begin
                run_txn(1'b1, 1'b0, 1'b1, m_resp(wt.lat, wt.err), 32'h0, hold);
            end else if (mode == 1) begin
                run_txn(1'b0, 1'b1, 1'b0, m_resp(rt.lat, rt.err), m_rdata(rt.lat, rt.data), hold);
            end else if (!model_last_write) begin
                run_txn(1'b1, 1'b1, 1'b1, m_resp(wt.lat, wt.err), 32'h0, hold);
                run_txn(1'b0, 1'b1, 1'b0, m_resp(rt.lat, rt.err), m_rdata(rt.lat, rt.data), 0);
            end else begin
                run_txn(1'b1, 1'b1, 1'b0, m_resp(rt.lat, rt.err), m_rdata(rt.lat, rt.data), hold);
                run_txn(1'b1, 1'b0, 1'b1, m_resp(wt.lat, wt.err), 32'h0, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
